// File: rtl/fazyrv_wbram_pkg.sv
// Shared types and constants for the Wishbone-to-RAM adapter.
package fazyrv_wbram_pkg;

    localparam int DATA_W = 32;
    localparam logic [3:0] SEL_FULL = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RDW,
        WR,
        ACK
    } wbram_state_t;

endpackage

// File: rtl/fazyrv_byte_merge.sv
// Combinational byte-lane merge: selected lanes come from new_data, the rest keep old_data.
module fazyrv_byte_merge
    import fazyrv_wbram_pkg::*;
(
    input  logic [DATA_W-1:0] old_data,
    input  logic [DATA_W-1:0] new_data,
    input  logic [3:0]        sel,
    output logic [DATA_W-1:0] merged
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign merged[gi*8 +: 8] = sel[gi] ? new_data[gi*8 +: 8] : old_data[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/fazyrv_wb_ram_adapter.sv
// Wishbone-classic slave in front of a single-port RAM without byte enables; partial stores are read-modify-write.
// Optional range checking with error response is enabled by defining FAZYRV_WBRAM_RANGE_CHK_EN.
module fazyrv_wb_ram_adapter
    import fazyrv_wbram_pkg::*;
#(
    parameter int ADRW  = 10,
    parameter int DEPTH = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              ram_we_o,
    output logic [ADRW-1:0]   ram_waddr_o,
    output logic [ADRW-1:0]   ram_raddr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i
);

    wbram_state_t state_reg, state_next;

    logic [ADRW-1:0]   idx_reg;
    logic [DATA_W-1:0] dat_reg;
    logic [3:0]        sel_reg;
    logic              we_reg;
    logic              err_reg;
    logic [DATA_W-1:0] merged_reg;
    logic [DATA_W-1:0] merged_next;
    logic [DATA_W-1:0] rdata_reg;

    logic              req_valid;
    logic [ADRW-1:0]   req_idx;
    logic              req_oor;
    logic              addr_unused;

    assign req_valid   = wb_cyc_i & wb_stb_i;
    assign req_idx     = wb_adr_i[ADRW+1:2];
    assign addr_unused = ^wb_adr_i;

`ifdef FAZYRV_WBRAM_RANGE_CHK_EN
    logic upper_nz;

    generate
        if (ADRW < 30) begin : g_upper
            assign upper_nz = |wb_adr_i[31:ADRW+2];
        end else begin : g_no_upper
            assign upper_nz = 1'b0;
        end
    endgenerate

    assign req_oor  = upper_nz | ({1'b0, req_idx} >= (ADRW+1)'(DEPTH));
    assign wb_err_o = (state_reg == ACK) & err_reg;
`else
    // Without range checking the index simply wraps, so DEPTH has no effect.
    localparam int DEPTH_UNUSED = DEPTH;
    assign req_oor  = 1'b0;
    assign wb_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (req_oor) begin
                        state_next = ACK;
                    end else if (!wb_we_i) begin
                        state_next = RD;
                    end else if (wb_sel_i == SEL_FULL) begin
                        state_next = WR;
                    end else if (wb_sel_i == 4'b0000) begin
                        state_next = ACK;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD:      state_next = RDW;
            RDW:     state_next = we_reg ? WR : ACK;
            WR:      state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    fazyrv_byte_merge u_merge (
        .old_data (ram_rdata_i),
        .new_data (dat_reg),
        .sel      (sel_reg),
        .merged   (merged_next)
    );

    // Request fields are captured only on acceptance so a master changing the bus mid-transaction has no effect.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_reg    <= '0;
            dat_reg    <= '0;
            sel_reg    <= '0;
            we_reg     <= 1'b0;
            err_reg    <= 1'b0;
            merged_reg <= '0;
            rdata_reg  <= '0;
        end else begin
            if (state_reg == IDLE && req_valid) begin
                idx_reg <= req_idx;
                dat_reg <= wb_dat_i;
                sel_reg <= wb_sel_i;
                we_reg  <= wb_we_i;
                err_reg <= req_oor;
            end
            if (state_reg == RDW) begin
                if (!we_reg) begin
                    rdata_reg <= ram_rdata_i;
                end
                merged_reg <= merged_next;
            end
        end
    end

    assign wb_ack_o    = (state_reg == ACK) & ~err_reg;
    assign wb_dat_o    = rdata_reg;
    assign ram_we_o    = (state_reg == WR);
    assign ram_waddr_o = idx_reg;
    assign ram_raddr_o = idx_reg;
    assign ram_wdata_o = (sel_reg == SEL_FULL) ? dat_reg : merged_reg;

endmodule

// File: tb/tb_fazyrv_wb_ram_adapter.sv
// Scoreboard bench for fazyrv_wb_ram_adapter: a driver queues expected responses, RAM writes and reads; monitors check them.
module tb_fazyrv_wb_ram_adapter;

    localparam int ADRW  = 10;
    localparam int DEPTH = 1024;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0]     wb_adr_i, wb_dat_i;
    logic [3:0]      wb_sel_i;
    logic [31:0]     wb_dat_o;
    logic            wb_ack_o, wb_err_o;
    logic            ram_we_o;
    logic [ADRW-1:0] ram_waddr_o, ram_raddr_o;
    logic [31:0]     ram_wdata_o, ram_rdata_i;

    fazyrv_wb_ram_adapter #(.ADRW(ADRW), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wb_cyc_i    (wb_cyc_i),
        .wb_stb_i    (wb_stb_i),
        .wb_we_i     (wb_we_i),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_sel_i    (wb_sel_i),
        .wb_dat_o    (wb_dat_o),
        .wb_ack_o    (wb_ack_o),
        .wb_err_o    (wb_err_o),
        .ram_we_o    (ram_we_o),
        .ram_waddr_o (ram_waddr_o),
        .ram_raddr_o (ram_raddr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int cycle_cnt = 0;
    int checks    = 0;
    int errors    = 0;

    always @(posedge clk_i) cycle_cnt <= cycle_cnt + 1;

    // RAM model: registered read, write on ram_we_o
    logic [31:0] mem [0:DEPTH-1];
    always @(posedge clk_i) begin
        if (ram_we_o) mem[ram_waddr_o] <= ram_wdata_o;
        ram_rdata_i <= mem[ram_raddr_o];
    end

    typedef struct {
        int          cyc;
        bit          err;
        bit          chk_dat;
        logic [31:0] dat;
        string       name;
    } rsp_t;

    typedef struct {
        int              cyc;
        logic [ADRW-1:0] adr;
        logic [31:0]     dat;
    } ram_t;

    rsp_t rsp_q[$];
    ram_t wr_q[$];
    ram_t rd_q[$];

    rsp_t mon_rsp;
    ram_t mon_wr;
    ram_t mon_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor
    always @(negedge clk_i) begin
        if (wb_ack_o && wb_err_o) begin
            checks++;
            errors++;
            $display("FAIL ack_err_both: ack=1 err=1 at cycle %0d, required at most one", cycle_cnt);
        end
        if (wb_ack_o || wb_err_o) begin
            if (rsp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: ack=%0b err=%0b at cycle %0d, required none", wb_ack_o, wb_err_o, cycle_cnt);
            end else begin
                mon_rsp = rsp_q.pop_front();
                check({mon_rsp.name, "_err"}, 32'(wb_err_o), 32'(mon_rsp.err));
                check({mon_rsp.name, "_cycle"}, 32'(cycle_cnt), 32'(mon_rsp.cyc));
                if (mon_rsp.chk_dat) check({mon_rsp.name, "_data"}, wb_dat_o, mon_rsp.dat);
                $display("txn %s: ack=%0b err=%0b dat=0x%08h cycle=%0d", mon_rsp.name, wb_ack_o, wb_err_o, wb_dat_o, cycle_cnt);
            end
        end
    end

    // RAM write monitor
    always @(negedge clk_i) begin
        if (ram_we_o) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ram_write: addr=%0d data=0x%08h at cycle %0d, required none", ram_waddr_o, ram_wdata_o, cycle_cnt);
            end else begin
                mon_wr = wr_q.pop_front();
                check("ram_write_cycle", 32'(cycle_cnt), 32'(mon_wr.cyc));
                check("ram_waddr", 32'(ram_waddr_o), 32'(mon_wr.adr));
                check("ram_wdata", ram_wdata_o, mon_wr.dat);
            end
        end
    end

    // RAM read-address monitor
    always @(negedge clk_i) begin
        if (rd_q.size() != 0 && cycle_cnt >= rd_q[0].cyc) begin
            mon_rd = rd_q.pop_front();
            check("ram_read_cycle", 32'(cycle_cnt), 32'(mon_rd.cyc));
            check("ram_raddr", 32'(ram_raddr_o), 32'(mon_rd.adr));
            check("ram_read_we_low", 32'(ram_we_o), 32'd0);
        end
    end

    // mode 0: wait one cycle then drive; 1: drive now, DUT still in ACK; 2: drive now, DUT idle
    task automatic issue(input string name, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input int mode,
                         input bit keep, input int lat, input bit exp_err, input bit chk_dat,
                         input logic [31:0] exp_dat, input int rd_at, input int wr_at,
                         input logic [31:0] wr_dat);
        rsp_t r;
        ram_t m;
        int   acc;
        bit   seen;
        if (mode == 0) @(negedge clk_i);
        acc = (mode == 1) ? cycle_cnt + 1 : cycle_cnt;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        r.cyc = acc + lat; r.err = exp_err; r.chk_dat = chk_dat; r.dat = exp_dat; r.name = name;
        rsp_q.push_back(r);
        if (rd_at >= 0) begin
            m.cyc = acc + rd_at; m.adr = adr[ADRW+1:2]; m.dat = '0;
            rd_q.push_back(m);
        end
        if (wr_at >= 0) begin
            m.cyc = acc + wr_at; m.adr = adr[ADRW+1:2]; m.dat = wr_dat;
            wr_q.push_back(m);
        end
        seen = 1'b0;
        for (int n = 0; n < 16 && !seen; n++) begin
            @(negedge clk_i);
            seen = wb_ack_o | wb_err_o;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no ack/err within 16 cycles, required one", name);
        end
        if (!keep) begin
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
            wb_we_i  = 1'b0;
        end
    endtask

    task automatic rd(input string name, input logic [31:0] adr, input logic [31:0] exp, input int mode, input bit keep);
        issue(name, 1'b0, adr, 32'h0, 4'hF, mode, keep, 3, 1'b0, 1'b1, exp, 1, -1, 32'h0);
    endtask

    task automatic wr_full(input string name, input logic [31:0] adr, input logic [31:0] dat);
        issue(name, 1'b1, adr, dat, 4'hF, 0, 1'b0, 2, 1'b0, 1'b0, 32'h0, -1, 1, dat);
    endtask

    task automatic wr_part(input string name, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] merged);
        issue(name, 1'b1, adr, dat, sel, 0, 1'b0, 4, 1'b0, 1'b0, 32'h0, 1, 3, merged);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
        rst_i    = 1'b1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = 32'h0;
        wb_dat_i = 32'h0;
        wb_sel_i = 4'h0;
        repeat (3) @(negedge clk_i);

        check("reset_ack", 32'(wb_ack_o), 32'd0);
        check("reset_err", 32'(wb_err_o), 32'd0);
        check("reset_dat", wb_dat_o, 32'h0);
        check("reset_we", 32'(ram_we_o), 32'd0);
        check("reset_waddr", 32'(ram_waddr_o), 32'd0);
        check("reset_raddr", 32'(ram_raddr_o), 32'd0);
        check("reset_wdata", ram_wdata_o, 32'h0);
        rst_i = 1'b0;

        // Full write then read
        wr_full("t1_wr", 32'h10, 32'hDEADBEEF);
        rd("t1_rd", 32'h10, 32'hDEADBEEF, 0, 1'b0);

        // Partial write (byte 1)
        wr_part("t2_wr", 32'h10, 32'h0000AA00, 4'b0010, 32'hDEADAAEF);
        rd("t2_rd", 32'h10, 32'hDEADAAEF, 0, 1'b0);

        // Empty-sel write
        issue("t3_wr", 1'b1, 32'h10, 32'h12345678, 4'b0000, 0, 1'b0, 1, 1'b0, 1'b0, 32'h0, -1, -1, 32'h0);
        rd("t3_rd", 32'h10, 32'hDEADAAEF, 0, 1'b0);

        // Out-of-range address
`ifdef FAZYRV_WBRAM_RANGE_CHK_EN
        issue("t4_oor", 1'b1, 32'h00010000, 32'hCAFEF00D, 4'hF, 0, 1'b0, 1, 1'b1, 1'b0, 32'h0, -1, -1, 32'h0);
        rd("t4_rd", 32'h0, 32'h0, 0, 1'b0);
`else
        wr_full("t4_wrap", 32'h00010000, 32'hCAFEF00D);
        rd("t4_rd", 32'h0, 32'hCAFEF00D, 0, 1'b0);
`endif

        // Reset during RDW of a partial write
        wr_full("t5_init", 32'h20, 32'h11223344);
        @(negedge clk_i);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 32'h20;
        wb_dat_i = 32'h000000FF;
        wb_sel_i = 4'b0001;
        mon_rd.cyc = cycle_cnt + 1;
        mon_rd.adr = 10'd8;
        mon_rd.dat = 32'h0;
        rd_q.push_back(mon_rd);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i    = 1'b1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        @(negedge clk_i);
        check("t5_no_we", 32'(ram_we_o), 32'd0);
        check("t5_no_ack", 32'(wb_ack_o), 32'd0);
        rst_i = 1'b0;
        rd("t5_rd", 32'h20, 32'h11223344, 2, 1'b0);

        // Another lane pattern, then back-to-back reads
        wr_full("t6_wr", 32'h14, 32'h0BADC0DE);
        wr_part("t6_part", 32'h14, 32'h55000066, 4'b1001, 32'h55ADC066);
        rd("t6_rd0", 32'h10, 32'hDEADAAEF, 0, 1'b1);
        rd("t6_rd1", 32'h14, 32'h55ADC066, 1, 1'b0);

        repeat (6) @(negedge clk_i);
        check("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
        check("wr_q_empty", 32'(wr_q.size()), 32'd0);
        check("rd_q_empty", 32'(rd_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fazyrv_wb_ram_adapter.md
# fazyrv_wb_ram_adapter

Wishbone-classic slave front-end for the SoC's single-port general-purpose RAM. It sits directly upstream of the RAM macro: it accepts CPU data-bus transactions and sequences RAM reads and writes. Because the RAM has no byte enables, partial-word stores are done as read-modify-write. It also handles address range checking and acknowledge generation.

## Interface

**Parameters**
- `ADRW`, default 10: RAM word-address width.
- `DEPTH`, default 1024: number of 32-bit RAM words; must be ≤ 2^ADRW.

**Ports** (one clock; reset is synchronous and active-high)
- `clk_i`  in  1: clock, rising edge.
- `rst_i`  in  1: synchronous active-high reset.
- `wb_cyc_i`  in  1: bus cycle valid.
- `wb_stb_i`  in  1: strobe.
- `wb_we_i`  in  1: write request.
- `wb_adr_i`  in  32: byte address.
- `wb_dat_i`  in  32: write data.
- `wb_sel_i`  in  4: byte select.
- `wb_dat_o`  out  32: read data, valid while `wb_ack_o` is high.
- `wb_ack_o`  out  1: one-cycle acknowledge.
- `wb_err_o`  out  1: one-cycle error; tied to 0 when `FAZYRV_WBRAM_RANGE_CHK_EN` is undefined.
- `ram_we_o`  out  1: RAM write enable.
- `ram_waddr_o`  out  ADRW: RAM write word address.
- `ram_raddr_o`  out  ADRW: RAM read word address.
- `ram_wdata_o`  out  32: RAM write data.
- `ram_rdata_i`  in  32: RAM read data. It is registered in the RAM and valid the cycle after the RAM samples a read with `we` low.

## Operation

- Word index is `wb_adr_i[ADRW+1:2]`. `wb_adr_i[1:0]` is ignored.
- A request is accepted only in IDLE, when `wb_cyc_i & wb_stb_i` is high at a clock edge. On acceptance the block latches the address, data, sel and we.
- All outputs are Moore-decoded from registered state and latched fields.
- FSM states: IDLE, RD, RDW, WR, ACK.
- Transitions out of IDLE:
  - Read, or write with sel not in {0000, 1111}: go to RD.
  - Write with sel = 1111: go to WR.
  - Write with sel = 0000: go to ACK. No RAM access is made.
  - Out-of-range request (macro enabled): go to ACK with error flagged.
- RD:
  - `ram_raddr_o` = latched index, `ram_we_o` = 0.
  - Next state is RDW.
- RDW: `ram_rdata_i` is valid in this state.
  - Read: `wb_dat_o` is registered from `ram_rdata_i`; next state is ACK.
  - Partial write: merged word = byte-wise `sel ? wdata : rdata`, registered; next state is WR.
- WR:
  - `ram_we_o` = 1, `ram_waddr_o` = latched index, `ram_wdata_o` = merged word (partial write) or latched data (full write).
  - Next state is ACK.
- ACK:
  - `wb_ack_o` = 1, or `wb_err_o` = 1 if error is flagged. Exactly one of the two is high, for exactly one cycle.
  - Next state is IDLE.
- An accepted transaction always runs to completion. Dropping `wb_cyc_i` mid-transaction neither aborts the RAM write nor suppresses the ack pulse.

## Timing

Request sampled in cycle 0:
- Read: ack in cycle 3.
- Full write: RAM write in cycle 1, ack in cycle 2.
- Partial write: RAM read in cycle 1, RAM write in cycle 3, ack in cycle 4.
- sel = 0000 write: ack in cycle 1.
- Error: err in cycle 1.

Back-to-back behaviour:
- After the ACK cycle the FSM is in IDLE, so a request still strobed in that next cycle is accepted as a new transaction.
- A master that drops `wb_stb_i` after seeing ack is never double-accepted.

Reset:
- Reset values: state IDLE, `wb_ack_o` = 0, `wb_err_o` = 0, `wb_dat_o` = 0, `ram_we_o` = 0, `ram_waddr_o` = 0, `ram_raddr_o` = 0, `ram_wdata_o` = 0, all latched fields 0.
- Reset mid-transaction returns the FSM to IDLE at the next edge with no ack and no further RAM write.
- A WR cycle in progress at that edge still commits, because the RAM samples the same edge.

## Configuration

`FAZYRV_WBRAM_RANGE_CHK_EN`:
- **Defined:** a request is out of range if `wb_adr_i[31:ADRW+2]` ≠ 0 or the word index ≥ DEPTH. Such a request makes no RAM access and gets `wb_err_o` for one cycle (no ack), with latency 1.
- **Undefined:** upper address bits are ignored. The index wraps to the low ADRW bits and the request completes normally with ack. `wb_err_o` is constant 0.

## Structure

- Package `fazyrv_wbram_pkg` holds:
  - the state enum typedef `wbram_state_t` (IDLE, RD, RDW, WR, ACK);
  - the constants for the full-word sel (`4'b1111`) and for data width 32.
- Sub-module `fazyrv_byte_merge` is purely combinational: it takes `old`[31:0], `new`[31:0] and `sel`[3:0] and produces `merged`[31:0]. It is instantiated once.

## Test plan

1. **Full write then read.** Write 0xDEADBEEF to byte address 0x10 with sel = 1111.
   - Required: `ram_we_o` pulses once in cycle 1 with waddr = 4, and ack comes in cycle 2.
   - Then read 0x10. Required: ack in cycle 3 with `wb_dat_o` = 0xDEADBEEF.
2. **Partial write.** Write 0x0000AA00 to 0x10 with sel = 0010.
   - Required: RAM read in cycle 1, `ram_wdata_o` = 0xDEADAAEF in cycle 3, ack in cycle 4.
   - A readback returns 0xDEADAAEF.
3. **Empty-sel write.** Write 0x12345678 with sel = 0000.
   - Required: ack in cycle 1, `ram_we_o` never asserted, word unchanged.
4. **Out-of-range address.** Write to 0x00010000 with DEPTH = 1024.
   - With the macro: err in cycle 1, no ack, no `ram_we_o`.
   - Without the macro: write lands at word 0, ack in cycle 2.
5. **Reset mid-RMW.** Assert `rst_i` during RDW of a partial write.
   - Required: next cycle is IDLE, no `ram_we_o`, no ack, and the target word is unchanged.
6. **Back-to-back.** Keep `wb_stb_i` high into the cycle after ack with a new read of 0x14.
   - Required: the second transaction is accepted in that cycle, and its ack follows 3 cycles later with the correct data.
